// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline stage register with valid/ready
// handshake, a main register plus one skid entry, and synchronous flush.
// Control bits are masked to zero whenever no entry is presented, so an
// empty or flushed stage cannot leak a write-enable downstream.
// Optional feature macro: PIPE_REG_STALL_CNT_EN adds a saturating counter of
// stalled cycles (out_valid & !out_ready). Without it, stall_cnt is tied to 0.
module pipe_stage_reg #(
   parameter int DATA_W = 96,
   parameter int CTRL_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic              m_valid;
   logic              s_valid;
   logic [CTRL_W-1:0] m_ctrl;
   logic [CTRL_W-1:0] s_ctrl;
   logic [DATA_W-1:0] m_data;
   logic [DATA_W-1:0] s_data;
   logic              acc;
   logic              drn;
   logic              load_main;

   // in_ready depends only on registered state, never on out_ready
   assign in_ready  = !s_valid;
   assign acc       = in_valid & in_ready;
   assign drn       = m_valid & out_ready;
   assign load_main = !m_valid | drn;

   assign out_valid = m_valid;
   assign out_ctrl  = m_valid ? m_ctrl : '0;
   assign out_data  = m_data;
   // skid is only ever filled while main is full, so occupancy is 0, 1 or 2
   assign occupancy = {m_valid & s_valid, m_valid ^ s_valid};

   // Valid flags: flush beats both accept and drain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid <= 1'b0;
         s_valid <= 1'b0;
      end else if (flush) begin
         m_valid <= 1'b0;
         s_valid <= 1'b0;
      end else if (load_main) begin
         if (s_valid) begin
            m_valid <= 1'b1;
            s_valid <= 1'b0;
         end else begin
            m_valid <= acc;
         end
      end else if (acc) begin
         s_valid <= 1'b1;
      end
   end

   // Payload registers: main refills from skid first to keep acceptance order
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ctrl <= '0;
         m_data <= '0;
         s_ctrl <= '0;
         s_data <= '0;
      end else if (!flush) begin
         if (load_main) begin
            if (s_valid) begin
               m_ctrl <= s_ctrl;
               m_data <= s_data;
            end else if (acc) begin
               m_ctrl <= in_ctrl;
               m_data <= in_data;
            end
         end else if (acc) begin
            s_ctrl <= in_ctrl;
            s_data <= in_data;
         end
      end
   end

`ifdef PIPE_REG_STALL_CNT_EN
   logic [CNT_W-1:0] stall_q;

   // Saturating stall counter; survives flush, cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
      end else if (m_valid && !out_ready && (stall_q != '1)) begin
         stall_q <= stall_q + 1'b1;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed bench for pipe_stage_reg. A queue of expected
// {ctrl,data} entries is pushed on each modelled accept and popped on each
// modelled drain; outputs are compared against its head every cycle.
module tb_pipe_stage_reg;
   localparam int DW = 96;
   localparam int CW = 8;
   localparam int NW = 4;
`ifdef PIPE_REG_STALL_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [CW-1:0] in_ctrl = '0;
   logic [DW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [CW-1:0] out_ctrl;
   logic [DW-1:0] out_data;
   logic [1:0]    occupancy;
   logic [NW-1:0] stall_cnt;

   logic [CW+DW-1:0] sb[$];
   int cnt_m  = 0;
   int checks = 0;
   int errors = 0;

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_data  (out_data),
      .occupancy (occupancy),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_now();
      int n;
      n = sb.size();
      chk("in_ready", 128'(in_ready), 128'(n != 2));
      chk("occupancy", 128'(occupancy), 128'(n));
      chk("out_valid", 128'(out_valid), 128'(n != 0));
      if (n != 0) begin
         chk("out_ctrl", 128'(out_ctrl), 128'(sb[0][CW+DW-1:DW]));
         chk("out_data", 128'(out_data), 128'(sb[0][DW-1:0]));
      end else begin
         chk("out_ctrl_bubble", 128'(out_ctrl), 128'(0));
      end
      chk("stall_cnt", 128'(stall_cnt), CNT_ON ? 128'(cnt_m) : 128'(0));
   endtask

   // Check current outputs, advance the model for this edge, then clock
   task automatic tick();
      bit acc_m;
      bit drn_m;
      check_now();
      acc_m = in_valid && (sb.size() != 2);
      drn_m = (sb.size() != 0) && out_ready;
      if ((sb.size() != 0) && !out_ready && (cnt_m < (2**NW - 1))) cnt_m++;
      if (flush) begin
         sb.delete();
      end else begin
         if (drn_m) void'(sb.pop_front());
         if (acc_m) sb.push_back({in_ctrl, in_data});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                        input bit ordy, input bit fl);
      in_valid  = v;
      in_ctrl   = c;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      tick();
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_out_data", 128'(out_data), 128'(0));
      check_now();

      // streaming with acc & drn at occupancy 1
      drive(1, 8'h11, 96'h1, 1, 0);
      drive(1, 8'h12, 96'h2, 1, 0);
      drive(1, 8'h13, 96'h3, 1, 0);
      drive(0, 8'hFF, 96'h0, 1, 0);

      // bubbles carrying all-ones control must show zero control
      for (int i = 0; i < 3; i++) drive(0, 8'hFF, '1, 1, 0);

      // backpressure: fill to two, third offer refused, then drain in order
      drive(1, 8'h21, 96'hA, 0, 0);
      drive(1, 8'h22, 96'hB, 0, 0);
      drive(1, 8'h23, 96'hC, 0, 0);
      drive(0, 8'h00, 96'h0, 1, 0);
      drive(0, 8'h00, 96'h0, 1, 0);
      drive(0, 8'h00, 96'h0, 1, 0);

      // flush a full stage while a new entry is offered
      drive(1, 8'h31, 96'hD, 0, 0);
      drive(1, 8'h32, 96'hE, 0, 0);
      drive(1, 8'h33, 96'hF, 0, 1);
      drive(0, 8'hFF, 96'h0, 1, 0);
      drive(0, 8'hFF, 96'h0, 1, 0);

      // stall counter saturation, then flush must not clear it
      drive(1, 8'h44, 96'h44, 0, 0);
      for (int i = 0; i < 20; i++) drive(0, 8'h00, 96'h0, 0, 0);
      drive(0, 8'h00, 96'h0, 0, 1);
      check_now();

      // async reset with two entries held, asserted between edges
      drive(1, 8'h51, 96'h51, 0, 0);
      drive(1, 8'h52, 96'h52, 0, 0);
      check_now();
      #3;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", 128'(out_valid), 128'(0));
      chk("arst_out_ctrl", 128'(out_ctrl), 128'(0));
      chk("arst_out_data", 128'(out_data), 128'(0));
      chk("arst_occupancy", 128'(occupancy), 128'(0));
      chk("arst_stall_cnt", 128'(stall_cnt), 128'(0));
      sb.delete();
      cnt_m = 0;
      @(posedge clk);
      #2;
      rst = 1'b0;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check_now();
      drive(1, 8'h61, 96'h61, 1, 0);
      drive(0, 8'h00, 96'h0, 1, 0);
      check_now();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
